// File: rtl/mreg_file_2r1w.sv
// mreg_file_2r1w: DEPTH x DATA_W register file, one write port, two
// independent registered read ports, and a clear sequencer that zeroes one
// entry per cycle after reset or on request.
// Optional build macro MREG_BYPASS_EN: when defined, a read that hits the
// address being written in the same cycle returns the new write data;
// otherwise it returns the value stored before the write.
module mreg_file_2r1w #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              clr_req,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b
);

    // One extra bit so DEPTH itself is representable (e.g. DEPTH=256).
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_next;

    logic              w_clearing;
    logic              w_wr_in_range;
    logic              w_wr_accept;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Per-port views so both read ports share one generate body.
    logic              w_rd_en    [2];
    logic [ADDR_W-1:0] w_rd_addr  [2];
    logic [DATA_W-1:0] w_rd_data  [2];
    logic              w_rd_valid [2];

    // State and clear-index register; reset always restarts the clear at 0.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state logic: walk every entry in CLEAR, leave after the last one;
    // in IDLE a clear request restarts the walk. Requests during CLEAR are ignored.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_CLEAR: begin
                if (r_idx == IDX_LAST) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_next = ST_CLEAR;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_idx_next   = '0;
            end
        endcase
    end

    assign ready      = (r_state == ST_IDLE);
    assign w_clearing = (r_state == ST_CLEAR);

    // A clear request in the same cycle wins over a user write.
    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
    assign w_wr_accept   = ready & wr_en & ~clr_req & w_wr_in_range;

    // The clear sequencer and the user write share the single RAM write port.
    assign w_mem_we    = w_clearing | w_wr_accept;
    assign w_mem_addr  = w_clearing ? r_idx : wr_addr;
    assign w_mem_wdata = w_clearing ? '0 : wr_data;

    // RAM write port; storage itself is not reset, the clear walk zeroes it.
    always_ff @(posedge sys_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign w_rd_en[0]   = rd_en_a;
    assign w_rd_en[1]   = rd_en_b;
    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic              w_in_range;
        logic              w_bypass;
        logic              w_accept;
        logic [DATA_W-1:0] r_rd_data;
        logic              r_rd_valid;

        assign w_in_range = ({1'b0, w_rd_addr[gi]} < DEPTH_C);
        assign w_accept   = ready & w_rd_en[gi];
`ifdef MREG_BYPASS_EN
        assign w_bypass   = w_wr_accept & (wr_addr == w_rd_addr[gi]);
`else
        assign w_bypass   = 1'b0;
`endif

        // Registered read: valid for exactly one cycle, data holds otherwise.
        always_ff @(posedge sys_clk) begin
            if (sys_reset) begin
                r_rd_valid <= 1'b0;
                r_rd_data  <= '0;
            end else begin
                r_rd_valid <= w_accept;
                if (w_accept) begin
                    if (!w_in_range) begin
                        r_rd_data <= '0;
                    end else if (w_bypass) begin
                        r_rd_data <= wr_data;
                    end else begin
                        r_rd_data <= r_mem[w_rd_addr[gi]];
                    end
                end
            end
        end

        assign w_rd_data[gi]  = r_rd_data;
        assign w_rd_valid[gi] = r_rd_valid;
    end

    assign rd_data_a  = w_rd_data[0];
    assign rd_valid_a = w_rd_valid[0];
    assign rd_data_b  = w_rd_data[1];
    assign rd_valid_b = w_rd_valid[1];

endmodule

// File: tb/tb_mreg_file_2r1w.sv
// tb_mreg_file_2r1w: drives a DEPTH=16 and a DEPTH=12 instance with the same
// stimulus. Each instance has its own reference model (clear countdown plus a
// plain array) feeding per-port expectation queues, and a monitor that checks
// ready every cycle and pops an expectation whenever rd_valid is seen.
module tb_mreg_file_2r1w;

`ifdef MREG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        clr_req;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en_a;
    logic [3:0]  rd_addr_a;
    logic        rd_en_b;
    logic [3:0]  rd_addr_b;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    always #5 sys_clk = ~sys_clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int DEP = (gi == 0) ? 16 : 12;

        logic        ready;
        logic [15:0] rd_data  [2];
        logic        rd_valid [2];

        mreg_file_2r1w #(.DATA_W(16), .DEPTH(DEP)) u_dut (
            .sys_clk    (sys_clk),
            .sys_reset  (sys_reset),
            .clr_req    (clr_req),
            .ready      (ready),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .rd_en_a    (rd_en_a),
            .rd_addr_a  (rd_addr_a),
            .rd_data_a  (rd_data[0]),
            .rd_valid_a (rd_valid[0]),
            .rd_en_b    (rd_en_b),
            .rd_addr_b  (rd_addr_b),
            .rd_data_b  (rd_data[1]),
            .rd_valid_b (rd_valid[1])
        );

        // Reference model state
        int          cyc      = 0;
        int          clr_left = 0;
        bit          seen_rst = 1'b0;
        logic [15:0] mem  [16];
        logic [15:0] last [2];
        exp_t        sb   [2][$];
        bit          m_en [2];
        int          m_ad [2];
        bit          m_wr_ok;
        exp_t        m_e;
        exp_t        c_e;

        // Model: busy for DEP cycles after reset/clear (all entries zero),
        // otherwise serve reads and apply the write.
        always @(posedge sys_clk) begin
            cyc++;
            m_en[0] = rd_en_a;
            m_en[1] = rd_en_b;
            m_ad[0] = int'(rd_addr_a);
            m_ad[1] = int'(rd_addr_b);
            if (sys_reset) begin
                seen_rst = 1'b1;
                clr_left = DEP;
                for (int i = 0; i < 16; i++) mem[i] = '0;
                last[0] = '0;
                last[1] = '0;
                sb[0].delete();
                sb[1].delete();
            end else if (clr_left > 0) begin
                clr_left--;
            end else begin
                m_wr_ok = wr_en && !clr_req && (int'(wr_addr) < DEP);
                for (int p = 0; p < 2; p++) begin
                    if (m_en[p]) begin
                        m_e.due = cyc;
                        if (m_ad[p] >= DEP)
                            m_e.data = '0;
                        else if (BYPASS && m_wr_ok && int'(wr_addr) == m_ad[p])
                            m_e.data = wr_data;
                        else
                            m_e.data = mem[m_ad[p]];
                        sb[p].push_back(m_e);
                    end
                end
                if (clr_req) begin
                    clr_left = DEP;
                    for (int i = 0; i < 16; i++) mem[i] = '0;
                end else if (m_wr_ok) begin
                    mem[wr_addr] = wr_data;
                end
            end
        end

        // Monitor: check ready, and match every rd_valid against the queue.
        always @(negedge sys_clk) begin
            if (seen_rst) begin
                tests++;
                if (ready !== (clr_left == 0)) begin
                    fails++;
                    $display("FAIL ready d%0d cyc %0d: got %b want %b", DEP, cyc, ready, (clr_left == 0));
                end
                for (int p = 0; p < 2; p++) begin
                    tests++;
                    if (rd_valid[p] === 1'b1) begin
                        if (sb[p].size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_valid d%0d port%0d cyc %0d: got valid=1 data=%h want valid=0",
                                     DEP, p, cyc, rd_data[p]);
                        end else begin
                            c_e = sb[p].pop_front();
                            last[p] = c_e.data;
                            if (rd_data[p] !== c_e.data || c_e.due != cyc) begin
                                fails++;
                                $display("FAIL read d%0d port%0d cyc %0d: got %h want %h (due cyc %0d)",
                                         DEP, p, cyc, rd_data[p], c_e.data, c_e.due);
                            end else begin
                                $display("[TB] d%0d port%0d cyc %0d read %h ok", DEP, p, cyc, rd_data[p]);
                            end
                        end
                    end else if (rd_valid[p] !== 1'b0) begin
                        fails++;
                        $display("FAIL valid_x d%0d port%0d cyc %0d: got %b want 0/1", DEP, p, cyc, rd_valid[p]);
                    end else if (sb[p].size() > 0 && sb[p][0].due <= cyc) begin
                        fails++;
                        $display("FAIL missing_valid d%0d port%0d cyc %0d: got valid=0 want valid=1 data=%h",
                                 DEP, p, cyc, sb[p][0].data);
                        void'(sb[p].pop_front());
                    end else if (rd_data[p] !== last[p]) begin
                        fails++;
                        $display("FAIL hold d%0d port%0d cyc %0d: got %h want %h", DEP, p, cyc, rd_data[p], last[p]);
                    end
                end
            end
        end
    end

    // One cycle of stimulus, applied just after a falling edge.
    task automatic drv(input bit rst, input bit clr, input bit we, input int wa, input int wd,
                       input bit ea, input int aa, input bit eb, input int ab);
        sys_reset = rst;
        clr_req   = clr;
        wr_en     = we;
        wr_addr   = 4'(wa);
        wr_data   = 16'(wd);
        rd_en_a   = ea;
        rd_addr_a = 4'(aa);
        rd_en_b   = eb;
        rd_addr_b = 4'(ab);
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        sys_reset = 1'b1;
        clr_req   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en_a   = 1'b0;
        rd_addr_a = '0;
        rd_en_b   = 1'b0;
        rd_addr_b = '0;
        @(negedge sys_clk);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset: ready low for DEPTH cycles, then every entry reads zero
        idle(17);
        for (int i = 0; i < 16; i++) drv(0, 0, 0, 0, 0, 1, i, 1, 15 - i);
        idle(2);

        // Write then read the same address on both ports
        drv(0, 0, 1, 3, 16'hBEEF, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 3, 1, 3);
        idle(2);

        // Same-cycle write and read of one address
        drv(0, 0, 1, 5, 16'h1111, 0, 0, 0, 0);
        drv(0, 0, 1, 5, 16'h2222, 1, 5, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 5, 1, 3);
        idle(2);

        // Clear wins over a same-cycle write; the read in that cycle is served
        drv(0, 1, 1, 2, 16'hAAAA, 1, 3, 0, 0);
        idle(17);
        drv(0, 0, 0, 0, 0, 1, 2, 1, 3);
        idle(2);

        // Out-of-range address (only for DEPTH=12): write ignored, read gives 0
        for (int i = 0; i < 12; i++) drv(0, 0, 1, i, 16'h0100 + i, 0, 0, 0, 0);
        drv(0, 0, 1, 13, 16'h5A5A, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 13, 1, 12);
        for (int i = 0; i < 16; i++) drv(0, 0, 0, 0, 0, 1, i, 1, i);
        idle(2);

        // Reset at clear index 7 with writes/reads requested throughout the clear
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) drv(0, 0, 1, 4, 16'h1234, 1, 4, 1, 0);
        drv(1, 0, 1, 4, 16'h1234, 1, 4, 1, 0);
        for (int i = 0; i < 16; i++) drv(0, 0, 1, 4, 16'h1234, 1, 4, 1, 0);
        drv(0, 0, 0, 0, 0, 1, 4, 1, 1);
        idle(2);

        // Randomized traffic, biased toward low addresses to hit collisions
        for (int n = 0; n < 1200; n++) begin
            bit r_rst;
            bit r_clr;
            int r_wa;
            int r_aa;
            int r_ab;
            r_rst = ($urandom_range(0, 299) == 0);
            r_clr = ($urandom_range(0, 63) == 0);
            r_wa  = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            r_aa  = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            r_ab  = $urandom_range(0, 1) ? r_wa : $urandom_range(0, 15);
            drv(r_rst, r_clr, $urandom_range(0, 1) == 1, r_wa, $urandom_range(0, 65535),
                $urandom_range(0, 1) == 1, r_aa, $urandom_range(0, 1) == 1, r_ab);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mreg_file_2r1w.md
MREG_FILE_2R1W -- requirements
Module: mreg_file_2r1w

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning entry count (2..256, any value).
REQ-003 SHALL have derived localparam ADDR_W = max(1, $clog2(DEPTH)).
REQ-004 SHALL have port sys_clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port sys_reset, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port clr_req, input, 1, meaning pulse to request a clear of all entries.
REQ-007 SHALL have port ready, output, 1, meaning 1 in IDLE and 0 in CLEAR.
REQ-008 SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_W) and wr_data (input, DATA_W), meaning the write port.
REQ-009 SHALL have ports rd_en_a (input, 1), rd_addr_a (input, ADDR_W), rd_data_a (output, DATA_W) and rd_valid_a (output, 1), meaning read port A.
REQ-010 SHALL have ports rd_en_b, rd_addr_b, rd_data_b and rd_valid_b, identical to port A, meaning read port B.

Function
REQ-011 SHALL implement FSM states CLEAR and IDLE; sys_reset forces CLEAR with clear index 0.
REQ-012 SHALL in CLEAR write 0 to entry[idx] and increment idx each cycle; after writing idx = DEPTH-1, go to IDLE on the next edge, so ready is 0 for exactly DEPTH cycles.
REQ-013 SHALL take clr_req=1 in IDLE to CLEAR with idx=0; clr_req SHALL be ignored in CLEAR, with no restart.
REQ-014 SHALL ignore wr_en, rd_en_a and rd_en_b while ready=0, and hold rd_valid_a and rd_valid_b at 0.
REQ-015 SHALL, on a write accepted (wr_en=1, ready=1, clr_req=0) at edge N, make the new value readable from a read issued at cycle N+1.
REQ-016 SHALL, on a read accepted at edge N, drive rd_data_x registered with rd_valid_x=1 during cycle N+1 only; rd_data_x SHALL hold its last value when rd_valid_x=0.
REQ-017 SHALL serve both read ports independently in the same cycle, including the same address.
REQ-018 SHALL, when clr_req=1 and wr_en=1 in the same IDLE cycle, let the clear win: the write is dropped, reads in that cycle are still served, and rd_valid is asserted next cycle.
REQ-019 SHALL, for an address >= DEPTH, ignore the write and return 0 on the read with rd_valid=1.
REQ-020 SHALL, for a same-cycle write and read of the same address, follow the behaviour set in Configuration.

Reset
REQ-021 SHALL on sys_reset set ready=0, rd_valid_a=rd_valid_b=0, rd_data_a=rd_data_b=0, state=CLEAR and idx=0.
REQ-022 SHALL, on sys_reset asserted mid-CLEAR, restart the clear from idx 0 and again hold ready=0 for DEPTH cycles after reset deasserts.
REQ-023 SHALL have all entries equal to 0 when ready first rises after any reset or clear.

Configuration
REQ-024 SHALL use macro MREG_BYPASS_EN to select same-address write/read behaviour.
REQ-025 SHALL, with MREG_BYPASS_EN defined, return wr_data (new value) for a same-cycle write and read of the same address.
REQ-026 SHALL, without MREG_BYPASS_EN, return the pre-write (old) value for a same-cycle write and read of the same address.

Verification
REQ-027 SHALL check: reset with DEPTH=16 -> ready=0 for 16 cycles then 1; reads of addresses 0..15 return 0x0000.
REQ-028 SHALL check: write 0xBEEF to address 3, then next cycle read A=3 and B=3 -> both ports return 0xBEEF with rd_valid=1 for one cycle.
REQ-029 SHALL check: with entry 5=0x1111, write 0x2222 to address 5 and read A=5 in the same cycle -> 0x2222 with MREG_BYPASS_EN, 0x1111 without.
REQ-030 SHALL check: clr_req and write 0xAAAA to address 2 in the same cycle -> ready=0 for DEPTH cycles, then a read of address 2 returns 0.
REQ-031 SHALL check: DEPTH=12, write address 13 then read address 13 -> 0 with rd_valid=1, and entries 0..11 are unchanged.
REQ-032 SHALL check: sys_reset at clear idx=7, and wr_en asserted during CLEAR -> clear restarts (16 cycles ready=0), the write is dropped and rd_valid stays 0.
